// File: rtl/sr_pkg.sv
// Shared types and constants for the SR pulse generator.
package sr_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } sr_state_t;

endpackage

// File: rtl/sr_down_cnt.sv
// Loadable down-counter shared by the PULSE and GAP phases; flags zero.
module sr_down_cnt
   import sr_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             LOAD,
   input  logic [CNT_W-1:0] LOAD_VAL,
   input  logic             DEC,
   output logic             ZERO
);

   logic [CNT_W-1:0] cnt_reg;

   // Load has priority; decrement saturates at zero so an idle counter stays put.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         cnt_reg <= '0;
      end else if (LOAD) begin
         cnt_reg <= LOAD_VAL;
      end else if (DEC && (cnt_reg != '0)) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign ZERO = (cnt_reg == '0);

endmodule

// File: rtl/sr_pulse_gen.sv
// Turns level set/clear requests into fixed-width S/R pulses with a forced gap.
// Optional conflict flag on ERR is built only when SR_CONFLICT_CHECK_EN is defined.
module sr_pulse_gen
   import sr_pkg::*;
#(
   parameter int PULSE_LEN = 3,
   parameter int GAP_LEN   = 2,
   parameter int PRIO_CLR  = 1
)(
   input  logic CLK,
   input  logic RST_N,
   input  logic SET_REQ,
   input  logic CLR_REQ,
   output logic S,
   output logic R,
   output logic ACK,
   output logic BUSY,
   output logic Q_EXP,
   output logic ERR
);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_LEN - 1);

   sr_state_t        state_reg;
   logic             s_reg;
   logic             r_reg;
   logic             ack_reg;
   logic             busy_reg;
   logic             q_exp_reg;
   logic             is_set_reg;

   logic             req_any;
   logic             pick_set;
   logic             cnt_zero;
   logic             cnt_load;
   logic             cnt_dec;
   logic [CNT_W-1:0] cnt_load_val;

   assign req_any  = SET_REQ | CLR_REQ;
   // With both requests high, set wins only when clear is not the priority side.
   assign pick_set = SET_REQ && (!CLR_REQ || (PRIO_CLR == 0));

   always_comb begin
      cnt_load     = 1'b0;
      cnt_load_val = PULSE_LD;
      cnt_dec      = (state_reg != IDLE);
      if ((state_reg == IDLE) && req_any) begin
         cnt_load = 1'b1;
      end else if ((state_reg == PULSE) && cnt_zero && (GAP_LEN != 0)) begin
         cnt_load     = 1'b1;
         cnt_load_val = GAP_LD;
      end
   end

   sr_down_cnt u_cnt (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .LOAD     (cnt_load),
      .LOAD_VAL (cnt_load_val),
      .DEC      (cnt_dec),
      .ZERO     (cnt_zero)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_reg  <= IDLE;
         s_reg      <= 1'b0;
         r_reg      <= 1'b0;
         ack_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         q_exp_reg  <= 1'b0;
         is_set_reg <= 1'b0;
      end else begin
         ack_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_any) begin
                  state_reg  <= PULSE;
                  busy_reg   <= 1'b1;
                  is_set_reg <= pick_set;
                  s_reg      <= pick_set;
                  r_reg      <= !pick_set;
               end
            end
            PULSE: begin
               if (cnt_zero) begin
                  s_reg     <= 1'b0;
                  r_reg     <= 1'b0;
                  ack_reg   <= 1'b1;
                  q_exp_reg <= is_set_reg;
                  if (GAP_LEN == 0) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg <= GAP;
                  end
               end
            end
            GAP: begin
               if (cnt_zero) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               s_reg     <= 1'b0;
               r_reg     <= 1'b0;
            end
         endcase
      end
   end

`ifdef SR_CONFLICT_CHECK_EN
   logic err_reg;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         err_reg <= 1'b0;
      end else if ((state_reg == IDLE) && SET_REQ && CLR_REQ) begin
         err_reg <= 1'b1;
      end
   end

   assign ERR = err_reg;
`else
   assign ERR = 1'b0;
`endif

   assign S     = s_reg;
   assign R     = r_reg;
   assign ACK   = ack_reg;
   assign BUSY  = busy_reg;
   assign Q_EXP = q_exp_reg;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Directed scoreboard bench for sr_pulse_gen: expected {S,R,ACK,BUSY,Q_EXP,ERR} per cycle.
module tb_sr_pulse_gen;

`ifdef SR_CONFLICT_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic set_a, clr_a, set_b, clr_b, set_c, clr_c;
   logic s_a, r_a, ack_a, busy_a, q_a, err_a;
   logic s_b, r_b, ack_b, busy_b, q_b, err_b;
   logic s_c, r_c, ack_c, busy_c, q_c, err_c;

   int   tests = 0;
   int   fails = 0;
   int   sel   = 0;
   logic exp_err = 1'b0;
   logic chk_on  = 1'b0;
   logic [5:0] exp_q [$];
   logic ack_a_d = 1'b0, ack_b_d = 1'b0, ack_c_d = 1'b0;

   // a: nominal 3/2 clear-priority, b: 1/0, c: set-priority
   sr_pulse_gen #(.PULSE_LEN(3), .GAP_LEN(2), .PRIO_CLR(1)) u_a (
      .CLK(clk), .RST_N(rst_n), .SET_REQ(set_a), .CLR_REQ(clr_a),
      .S(s_a), .R(r_a), .ACK(ack_a), .BUSY(busy_a), .Q_EXP(q_a), .ERR(err_a));
   sr_pulse_gen #(.PULSE_LEN(1), .GAP_LEN(0), .PRIO_CLR(1)) u_b (
      .CLK(clk), .RST_N(rst_n), .SET_REQ(set_b), .CLR_REQ(clr_b),
      .S(s_b), .R(r_b), .ACK(ack_b), .BUSY(busy_b), .Q_EXP(q_b), .ERR(err_b));
   sr_pulse_gen #(.PULSE_LEN(3), .GAP_LEN(2), .PRIO_CLR(0)) u_c (
      .CLK(clk), .RST_N(rst_n), .SET_REQ(set_c), .CLR_REQ(clr_c),
      .S(s_c), .R(r_c), .ACK(ack_c), .BUSY(busy_c), .Q_EXP(q_c), .ERR(err_c));

   function automatic logic [5:0] obs();
      case (sel)
         1:       return {s_b, r_b, ack_b, busy_b, q_b, err_b};
         2:       return {s_c, r_c, ack_c, busy_c, q_c, err_c};
         default: return {s_a, r_a, ack_a, busy_a, q_a, err_a};
      endcase
   endfunction

   task automatic push(input logic s, input logic r, input logic ack, input logic busy, input logic q);
      exp_q.push_back({s, r, ack, busy, q, exp_err});
   endtask

   task automatic push_idle(input int n, input logic q);
      for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, q);
   endtask

   // One full pulse as seen after its sampling edge, ending with the idle cycle before the next sample.
   task automatic push_pulse(input logic is_set, input int plen, input int glen, input logic q_old);
      for (int i = 0; i < plen; i++) push(is_set, !is_set, 1'b0, 1'b1, q_old);
      push(1'b0, 1'b0, 1'b1, (glen != 0), is_set);
      if (glen > 0) begin
         for (int i = 1; i < glen; i++) push(1'b0, 1'b0, 1'b0, 1'b1, is_set);
         push(1'b0, 1'b0, 1'b0, 1'b0, is_set);
      end
   endtask

   task automatic run(input int n, input string tag);
      logic [5:0] exp_v;
      logic [5:0] got_v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         tests++;
         got_v = obs();
         if (exp_q.size() == 0) begin
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL %s cyc%0d: observed %b with no expected entry", tag, i, got_v);
            end
         end else begin
            exp_v = exp_q.pop_front();
            assert (got_v === exp_v) else begin
               fails++;
               $error("FAIL %s cyc%0d: observed SRABQE=%b expected %b", tag, i, got_v, exp_v);
            end
         end
         $display("[TB] %s cyc%0d inst%0d SRABQE=%b", tag, i, sel, got_v);
      end
   endtask

   // Invariants checked on every cycle for all instances.
   always @(negedge clk) begin
      if (chk_on) begin
         tests++;
         assert (!(s_a && r_a) && !(s_b && r_b) && !(s_c && r_c)) else begin
            fails++;
            $error("FAIL s_and_r: observed a=%b%b b=%b%b c=%b%b expected never both", s_a, r_a, s_b, r_b, s_c, r_c);
         end
         tests++;
         assert (!(ack_a && ack_a_d) && !(ack_b && ack_b_d) && !(ack_c && ack_c_d)) else begin
            fails++;
            $error("FAIL ack_back_to_back: observed a=%b%b b=%b%b c=%b%b expected no consecutive ACK",
                   ack_a_d, ack_a, ack_b_d, ack_b, ack_c_d, ack_c);
         end
      end
      ack_a_d <= ack_a;
      ack_b_d <= ack_b;
      ack_c_d <= ack_c;
   end

   initial begin
      rst_n = 1'b0;
      set_a = 1'b0; clr_a = 1'b0;
      set_b = 1'b0; clr_b = 1'b0;
      set_c = 1'b0; clr_c = 1'b0;

      // reset state
      push_idle(2, 1'b0);
      run(2, "reset");
      chk_on = 1'b1;

      // single set request, sampled on first edge out of reset
      rst_n = 1'b1;
      set_a = 1'b1;
      push_pulse(1'b1, 3, 2, 1'b0);
      run(1, "set_single");
      set_a = 1'b0;
      run(5, "set_single");
      push_idle(2, 1'b1);
      run(2, "set_idle");

      // clear held 20 cycles: pulses every 6 cycles
      clr_a = 1'b1;
      push_pulse(1'b0, 3, 2, 1'b1);
      push_pulse(1'b0, 3, 2, 1'b0);
      push_pulse(1'b0, 3, 2, 1'b0);
      push_pulse(1'b0, 3, 2, 1'b0);
      run(20, "clr_held");
      clr_a = 1'b0;
      run(4, "clr_held");
      push_idle(2, 1'b0);
      run(2, "clr_idle");

      // conflict with clear priority, then sticky ERR across a set pulse
      set_a = 1'b1; clr_a = 1'b1;
      exp_err = ERR_ON;
      push_pulse(1'b0, 3, 2, 1'b0);
      run(1, "conflict_clr");
      set_a = 1'b0; clr_a = 1'b0;
      run(5, "conflict_clr");
      push_idle(1, 1'b0);
      run(1, "conflict_idle");
      set_a = 1'b1;
      push_pulse(1'b1, 3, 2, 1'b0);
      run(1, "err_sticky");
      set_a = 1'b0;
      run(5, "err_sticky");

      // conflict with set priority on instance c
      sel = 2;
      set_c = 1'b1; clr_c = 1'b1;
      exp_err = ERR_ON;
      push_pulse(1'b1, 3, 2, 1'b0);
      run(1, "conflict_set");
      set_c = 1'b0; clr_c = 1'b0;
      run(5, "conflict_set");

      // reset during the second pulse cycle aborts without ACK
      sel = 0;
      exp_err = ERR_ON;
      set_a = 1'b1;
      push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      run(1, "abort_pulse");
      set_a = 1'b0;
      push(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      run(1, "abort_pulse");
      rst_n = 1'b0;
      exp_err = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run(1, "abort_reset");
      rst_n = 1'b1;
      push_idle(5, 1'b0);
      run(5, "abort_no_ack");

      // PULSE_LEN=1, GAP_LEN=0 with set held: pulse and ACK every 2 cycles
      sel = 1;
      exp_err = 1'b0;
      set_b = 1'b1;
      push_pulse(1'b1, 1, 0, 1'b0);
      push_pulse(1'b1, 1, 0, 1'b1);
      push_pulse(1'b1, 1, 0, 1'b1);
      run(6, "nogap_held");
      set_b = 1'b0;
      push_idle(2, 1'b1);
      run(2, "nogap_idle");

      tests++;
      assert (exp_q.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d entries left expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
